line_matrix_sequencer: RTL and testbench

- Configuration sequencer for a line-matrix built from NUM_OUTPUTS line_mux instances with IDs 0..NUM_OUTPUTS-1.
- All mux instances share one input_select/output_select bus, which this block drives.
- Software fills a shadow route table (one entry per output). A commit handshake then sweeps the table onto the shared bus, one output per cycle.
- The block keeps an active table that mirrors exactly what every mux currently holds.

---
 rtl/line_matrix_sequencer_pkg.sv | 19 +
 rtl/line_matrix_sequencer_route_table.sv | 80 ++++++++
 rtl/line_matrix_sequencer.sv | 115 +++++++++++
 tb/tb_line_matrix_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_matrix_sequencer_pkg.sv
// Shared types and constants for the line-matrix sequencer.
// FSM states, selector encodings and a width helper.
package line_matrix_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } seq_state_t;

  localparam int SEL_ZERO     = 0;
  localparam int SEL_ONE      = 1;
  localparam int SEL_LINE_OFS = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_matrix_sequencer_route_table.sv
// line_route_table: shadow/active route tables, write checks, copy port.
// Ports: cfg write (wr_*), err pulse, copy_en/copy_idx (shadow->active),
//   peek_idx/peek_shadow (shadow read with same-cycle write forwarding),
//   active_zero. LINE_MATRIX_SEQ_READBACK_EN adds rd_addr/rd_data.
module line_route_table
  import line_matrix_pkg::*;
#(
  parameter int NUM_INPUTS = 10,
  parameter int NUM_OUTPUTS = 10,
  localparam int ISEL_W = sel_width(NUM_INPUTS + 2),
  localparam int OSEL_W = sel_width(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OSEL_W-1:0] wr_addr,
  input  logic [ISEL_W-1:0] wr_data,
  input  logic              wr_allow,
  output logic              err,
  input  logic              copy_en,
  input  logic [OSEL_W-1:0] copy_idx,
  input  logic [OSEL_W-1:0] peek_idx,
  output logic [ISEL_W-1:0] peek_shadow,
`ifdef LINE_MATRIX_SEQ_READBACK_EN
  input  logic [OSEL_W-1:0] rd_addr,
  output logic [ISEL_W-1:0] rd_data,
`endif
  output logic [ISEL_W-1:0] active_zero
);

  localparam int MAX_SEL = NUM_INPUTS + 1;

  logic [ISEL_W-1:0] shadow [NUM_OUTPUTS];
  logic [ISEL_W-1:0] active [NUM_OUTPUTS];

  logic addr_ok;
  logic data_ok;
  logic wr_ok;

  assign addr_ok = int'(wr_addr) < NUM_OUTPUTS;
  assign data_ok = int'(wr_data) <= MAX_SEL;
  assign wr_ok   = wr_en & wr_allow & addr_ok & data_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) begin
        shadow[i] <= ISEL_W'(SEL_ZERO);
        active[i] <= ISEL_W'(SEL_ZERO);
      end
    end else begin
      err <= wr_en & ~wr_ok;
      if (wr_ok)
        shadow[wr_addr] <= wr_data;
      if (copy_en)
        active[copy_idx] <= shadow[copy_idx];
    end
  end

  // A write accepted on the commit edge must reach the first swept entry.
  always_comb begin
    peek_shadow = shadow[peek_idx];
    if (wr_ok && wr_addr == peek_idx)
      peek_shadow = wr_data;
  end

  assign active_zero = active[0];

`ifdef LINE_MATRIX_SEQ_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= '0;
    else if (int'(rd_addr) < NUM_OUTPUTS)
      rd_data <= active[rd_addr];
    else
      rd_data <= '0;
  end
`endif

endmodule

// File: rtl/line_matrix_sequencer.sv
// line_matrix_sequencer: sweeps a shadow route table onto the shared
// line_mux select bus on commit. Ports: clk, rst, cfg_wr_*, cfg_err,
// commit_valid/ready, busy, done, output_select, input_select.
// LINE_MATRIX_SEQ_READBACK_EN adds cfg_rd_addr/cfg_rd_data.
module line_matrix_sequencer
  import line_matrix_pkg::*;
#(
  parameter int NUM_INPUTS = 10,
  parameter int NUM_OUTPUTS = 10,
  localparam int ISEL_W = sel_width(NUM_INPUTS + 2),
  localparam int OSEL_W = sel_width(NUM_OUTPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_wr_en,
  input  logic [OSEL_W-1:0] cfg_wr_addr,
  input  logic [ISEL_W-1:0] cfg_wr_data,
  output logic              cfg_err,
`ifdef LINE_MATRIX_SEQ_READBACK_EN
  input  logic [OSEL_W-1:0] cfg_rd_addr,
  output logic [ISEL_W-1:0] cfg_rd_data,
`endif
  input  logic              commit_valid,
  output logic              commit_ready,
  output logic              busy,
  output logic              done,
  output logic [OSEL_W-1:0] output_select,
  output logic [ISEL_W-1:0] input_select
);

  seq_state_t        state;
  logic [OSEL_W-1:0] idx;
  logic              last;
  logic [OSEL_W-1:0] peek_idx;
  logic [ISEL_W-1:0] peek_shadow;
  logic [ISEL_W-1:0] active_zero;

  assign last = (idx == OSEL_W'(NUM_OUTPUTS - 1));
  assign commit_ready = (state == S_IDLE);

  // Next entry to put on the bus; entry 0 at commit and on the final step.
  assign peek_idx = (state == S_SWEEP && !last)
                  ? OSEL_W'(idx + 1'b1) : '0;

  line_route_table #(
    .NUM_INPUTS (NUM_INPUTS),
    .NUM_OUTPUTS(NUM_OUTPUTS)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (cfg_wr_en),
    .wr_addr    (cfg_wr_addr),
    .wr_data    (cfg_wr_data),
    .wr_allow   (state != S_SWEEP),
    .err        (cfg_err),
    .copy_en    (state == S_SWEEP),
    .copy_idx   (idx),
    .peek_idx   (peek_idx),
    .peek_shadow(peek_shadow),
`ifdef LINE_MATRIX_SEQ_READBACK_EN
    .rd_addr    (cfg_rd_addr),
    .rd_data    (cfg_rd_data),
`endif
    .active_zero(active_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      output_select <= '0;
      input_select  <= ISEL_W'(SEL_ZERO);
    end else begin
      unique case (state)
        S_IDLE: begin
          done          <= 1'b0;
          output_select <= '0;
          if (commit_valid) begin
            state        <= S_SWEEP;
            idx          <= '0;
            busy         <= 1'b1;
            input_select <= peek_shadow;
          end else begin
            busy         <= 1'b0;
            input_select <= active_zero;
          end
        end
        S_SWEEP: begin
          if (last) begin
            state         <= S_DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            output_select <= '0;
            input_select  <= peek_shadow;
          end else begin
            idx           <= OSEL_W'(idx + 1'b1);
            output_select <= OSEL_W'(idx + 1'b1);
            input_select  <= peek_shadow;
          end
        end
        S_DONE: begin
          state         <= S_IDLE;
          done          <= 1'b0;
          busy          <= 1'b0;
          output_select <= '0;
          input_select  <= active_zero;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_matrix_sequencer.sv
// Self-checking bench for line_matrix_sequencer against a table model.
// Optional readback checks follow LINE_MATRIX_SEQ_READBACK_EN.
module tb_line_matrix_sequencer;

  localparam int N = 10;
  localparam int NI = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_wr_en = 1'b0;
  logic [3:0] cfg_wr_addr = '0;
  logic [3:0] cfg_wr_data = '0;
  logic       cfg_err;
  logic       commit_valid = 1'b0;
  logic       commit_ready;
  logic       busy;
  logic       done;
  logic [3:0] output_select;
  logic [3:0] input_select;
`ifdef LINE_MATRIX_SEQ_READBACK_EN
  logic [3:0] cfg_rd_addr = '0;
  logic [3:0] cfg_rd_data;
`endif

  always #5 clk = ~clk;

  line_matrix_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_wr_en    (cfg_wr_en),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_err      (cfg_err),
`ifdef LINE_MATRIX_SEQ_READBACK_EN
    .cfg_rd_addr  (cfg_rd_addr),
    .cfg_rd_data  (cfg_rd_data),
`endif
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .busy         (busy),
    .done         (done),
    .output_select(output_select),
    .input_select (input_select)
  );

  int shadow_m [N];
  int active_m [N];
  int n_chk = 0;
  int n_fail = 0;

  // External line_mux with ID 3, used to see a route actually land.
  logic [NI-1:0] lines;
  logic [3:0]    mux3_sel;
  logic          mux3_out;

  always_ff @(posedge clk) begin
    if (rst)
      mux3_sel <= '0;
    else if (output_select == 4'd3)
      mux3_sel <= input_select;
  end

  always_comb begin
    mux3_out = 1'b0;
    if (mux3_sel == 4'd1)
      mux3_out = 1'b1;
    else if (mux3_sel >= 4'd2 && int'(mux3_sel) < NI + 2)
      mux3_out = lines[int'(mux3_sel) - 2];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit wr_valid(input int a, input int d);
    return (a < N) && (d <= NI + 1);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      shadow_m[i] = 0;
      active_m[i] = 0;
    end
  endtask

  task automatic do_write(input int a, input int d);
    bit ok;
    ok = wr_valid(a, d);
    @(negedge clk);
    cfg_wr_en = 1'b1;
    cfg_wr_addr = 4'(a);
    cfg_wr_data = 4'(d);
    @(negedge clk);
    cfg_wr_en = 1'b0;
    chk("wr_err", 32'(cfg_err), 32'(!ok));
    if (ok)
      shadow_m[a] = d;
  endtask

  // inj: sweep index at which a (rejected) write is attempted, -1 none.
  // rst_at: sweep index at which reset is pulsed, -1 none.
  task automatic do_commit(input int inj, input int rst_at,
                           input bit wsame, input int wa, input int wd);
    bit ok;
    @(negedge clk);
    chk("ready_pre", 32'(commit_ready), 1);
    commit_valid = 1'b1;
    if (wsame) begin
      cfg_wr_en = 1'b1;
      cfg_wr_addr = 4'(wa);
      cfg_wr_data = 4'(wd);
    end
    @(negedge clk);
    commit_valid = 1'b0;
    cfg_wr_en = 1'b0;
    ok = wsame && wr_valid(wa, wd);
    if (ok)
      shadow_m[wa] = wd;
    for (int i = 0; i < N; i++) begin
      if (i > 0)
        @(negedge clk);
      cfg_wr_en = 1'b0;
      chk("sw_out", 32'(output_select), i);
      chk("sw_in", 32'(input_select), shadow_m[i]);
      chk("sw_busy", 32'(busy), 1);
      chk("sw_done", 32'(done), 0);
      chk("sw_ready", 32'(commit_ready), 0);
      chk("sw_err", 32'(cfg_err),
          32'((i == 0 && wsame && !ok) || (inj >= 0 && i == inj + 1)));
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        chk("rst_out", 32'(output_select), 0);
        chk("rst_in", 32'(input_select), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(commit_ready), 1);
        for (int k = 0; k < N + 2; k++) begin
          chk("rst_nodone", 32'(done), 0);
          @(negedge clk);
        end
        return;
      end
      active_m[i] = shadow_m[i];
      if (i == inj) begin
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 4'(wa);
        cfg_wr_data = 4'(wd);
      end
    end
    @(negedge clk);
    cfg_wr_en = 1'b0;
    chk("dn_done", 32'(done), 1);
    chk("dn_busy", 32'(busy), 0);
    chk("dn_ready", 32'(commit_ready), 0);
    chk("dn_out", 32'(output_select), 0);
    chk("dn_in", 32'(input_select), shadow_m[0]);
    @(negedge clk);
    chk("id_done", 32'(done), 0);
    chk("id_ready", 32'(commit_ready), 1);
    chk("id_out", 32'(output_select), 0);
    chk("id_in", 32'(input_select), active_m[0]);
  endtask

  initial begin
    lines = NI'($urandom);
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out", 32'(output_select), 0);
    chk("rst_in", 32'(input_select), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_ready", 32'(commit_ready), 1);

    do_commit(-1, -1, 1'b0, 0, 0);

    do_write(3, 5);
    do_write(9, 11);
    do_commit(-1, -1, 1'b0, 0, 0);
    chk("mux3", 32'(mux3_out), 32'(lines[3]));
`ifdef LINE_MATRIX_SEQ_READBACK_EN
    @(negedge clk);
    cfg_rd_addr = 4'd3;
    @(negedge clk);
    chk("rd3", 32'(cfg_rd_data), 5);
    cfg_rd_addr = 4'd15;
    @(negedge clk);
    chk("rd15", 32'(cfg_rd_data), 0);
`endif

    do_write(10, 4);
    do_write(4, 12);
    do_commit(-1, -1, 1'b0, 0, 0);

    do_commit(2, -1, 1'b0, 2, 7);
    do_commit(-1, -1, 1'b1, 0, 6);

    for (int r = 0; r < 12; r++) begin
      int nw;
      int inj;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        do_write($urandom_range(0, 11), $urandom_range(0, 13));
      inj = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 2) : -1;
      do_commit(inj, -1, $urandom_range(0, 2) == 0,
                $urandom_range(0, 11), $urandom_range(0, 13));
    end

    do_write(5, 8);
    do_commit(-1, 4, 1'b0, 0, 0);
    do_commit(-1, -1, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
